// File: rtl/uart_apb_pkg.sv
// ---------------------------------------------------------------------------
// uart_apb_pkg
// Shared definitions for the UART-to-APB bridge: command codes received from
// the host, status codes returned to it, and the state encodings of the
// frame/bus FSM and of the response transmitter.
// ---------------------------------------------------------------------------
package uart_apb_pkg;

    // Command bytes that open a frame
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    // First byte of every response
    localparam logic [7:0] STS_OK      = 8'h00;
    localparam logic [7:0] STS_SLVERR  = 8'h01;
    localparam logic [7:0] STS_TIMEOUT = 8'h02;

    // Frame decode / APB sequencing FSM
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } state_e;

    // Response transmitter FSM
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_WAIT_LO,
        TX_WAIT_HI
    } tx_state_e;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

endpackage

// File: rtl/uart_apb_master_if.sv
// ---------------------------------------------------------------------------
// uart_apb_master_if
// APB3 bus bundle between the bridge (master) and a peripheral (slave).
//   paddr/psel/penable/pwrite/pwdata : master -> slave
//   prdata/pready/pslverr            : slave  -> master
// ---------------------------------------------------------------------------
interface uart_apb_master_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/resp_shifter.sv
// ---------------------------------------------------------------------------
// resp_shifter
// Sends a 1- or 5-byte response, MSB byte first, over a start/done PHY
// handshake.
//   clk, arstn   : clock, asynchronous active-low reset
//   load_i       : one-cycle strobe, latch data_i / nbytes_i (ignored if busy)
//   data_i       : response bytes, first byte in [39:32]
//   nbytes_i     : number of bytes to send (1 or 5)
//   done_tx_i    : PHY transmitter idle
//   byte_tx_o    : byte presented to the PHY
//   start_tx_o   : one-cycle launch strobe for byte_tx_o
//   done_o       : one-cycle strobe after the last byte has completed
// ---------------------------------------------------------------------------
module resp_shifter
    import uart_apb_pkg::*;
(
    input  logic        clk,
    input  logic        arstn,
    input  logic        load_i,
    input  logic [39:0] data_i,
    input  logic [2:0]  nbytes_i,
    input  logic        done_tx_i,
    output logic [7:0]  byte_tx_o,
    output logic        start_tx_o,
    output logic        done_o
);

    tx_state_e   st_q, st_d;
    logic [39:0] sh_q, sh_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  byte_q, byte_d;
    logic        start_q, start_d;
    logic        done_q, done_d;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            st_q    <= TX_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        case (st_q)
            TX_IDLE: begin
                if (load_i) begin
                    sh_d  = data_i;
                    cnt_d = nbytes_i;
                    st_d  = TX_START;
                end
            end
            TX_START: begin
                // Launch only into an idle PHY; byte and strobe register together
                if (done_tx_i) begin
                    byte_d  = sh_q[39:32];
                    sh_d    = {sh_q[31:0], 8'h00};
                    cnt_d   = cnt_q - 3'd1;
                    start_d = 1'b1;
                    st_d    = TX_WAIT_LO;
                end
            end
            TX_WAIT_LO: begin
                // The PHY must acknowledge by going busy before we look for idle again
                if (!done_tx_i) begin
                    st_d = TX_WAIT_HI;
                end
            end
            TX_WAIT_HI: begin
                if (done_tx_i) begin
                    if (cnt_q == 3'd0) begin
                        done_d = 1'b1;
                        st_d   = TX_IDLE;
                    end else begin
                        st_d = TX_START;
                    end
                end
            end
            default: st_d = TX_IDLE;
        endcase
    end

    assign byte_tx_o  = byte_q;
    assign start_tx_o = start_q;
    assign done_o     = done_q;

endmodule

// File: rtl/uart_apb_master.sv
// ---------------------------------------------------------------------------
// uart_apb_master
// Decodes command frames from a UART byte stream into single APB transfers
// and returns a status (plus read data) over the UART transmitter.
// Frame: cmd (0x57 write / 0x52 read), 4 address bytes MSB first,
//        write only: 4 data bytes MSB first.
// Ports:
//   clk, arstn          : clock, asynchronous active-low reset
//   byte_rx/new_byte_rx : received byte and its one-cycle valid strobe
//   byte_tx/start_tx    : response byte and its one-cycle launch strobe
//   done_tx             : PHY transmitter idle
//   apb                 : APB master bus
// Parameters:
//   INTERBYTE_TIMEOUT   : max clk cycles between bytes of one frame
//   APB_TIMEOUT         : max ACCESS cycles waiting for pready
// ---------------------------------------------------------------------------
module uart_apb_master
    import uart_apb_pkg::*;
#(
    parameter int INTERBYTE_TIMEOUT = 104160,
    parameter int APB_TIMEOUT       = 1024
) (
    input  logic                     clk,
    input  logic                     arstn,
    input  logic [7:0]               byte_rx,
    input  logic                     new_byte_rx,
    output logic [7:0]               byte_tx,
    output logic                     start_tx,
    input  logic                     done_tx,
    uart_apb_master_if.master        apb
);

    // Gap counter must reach INTERBYTE_TIMEOUT+1 to detect the overrun
    localparam int IBW = $clog2(INTERBYTE_TIMEOUT + 2);
    localparam int WTW = $clog2(APB_TIMEOUT + 1);
    localparam logic [IBW-1:0] IB_LIMIT = IBW'(INTERBYTE_TIMEOUT);
    localparam logic [WTW-1:0] WT_LAST  = WTW'(APB_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [IBW-1:0]   ib_q, ib_d;
    logic [WTW-1:0]   wt_q, wt_d;
    logic [31:0]      paddr_q, paddr_d;
    logic [31:0]      pwdata_q, pwdata_d;
    logic             pwrite_q, pwrite_d;

    logic             rsp_load;
    logic [39:0]      rsp_data;
    logic [2:0]       rsp_nbytes;
    logic             rsp_done;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q  <= ST_IDLE;
            bcnt_q   <= '0;
            ib_q     <= '0;
            wt_q     <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            ib_q     <= ib_d;
            wt_q     <= wt_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        ib_d       = ib_q;
        wt_d       = wt_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pwrite_d   = pwrite_q;
        rsp_load   = 1'b0;
        rsp_data   = '0;
        rsp_nbytes = 3'd1;
        case (state_q)
            ST_IDLE: begin
                if (new_byte_rx && is_cmd(byte_rx)) begin
                    pwrite_d = (byte_rx == CMD_WRITE);
                    bcnt_d   = 2'd0;
                    // ib counts cycles elapsed since the last accepted byte
                    ib_d     = IBW'(1);
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (ib_q > IB_LIMIT) begin
                    state_d = ST_IDLE;
                end else if (new_byte_rx) begin
                    paddr_d = {paddr_q[23:0], byte_rx};
                    bcnt_d  = bcnt_q + 2'd1;
                    ib_d    = IBW'(1);
                    if (bcnt_q == 2'd3) begin
                        state_d = pwrite_q ? ST_WDATA : ST_SETUP;
                    end
                end else begin
                    ib_d = ib_q + IBW'(1);
                end
            end
            ST_WDATA: begin
                if (ib_q > IB_LIMIT) begin
                    state_d = ST_IDLE;
                end else if (new_byte_rx) begin
                    pwdata_d = {pwdata_q[23:0], byte_rx};
                    bcnt_d   = bcnt_q + 2'd1;
                    ib_d     = IBW'(1);
                    if (bcnt_q == 2'd3) begin
                        state_d = ST_SETUP;
                    end
                end else begin
                    ib_d = ib_q + IBW'(1);
                end
            end
            ST_SETUP: begin
                wt_d    = '0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Response is built here so read data is taken in the pready cycle
                if (apb.pready) begin
                    rsp_load   = 1'b1;
                    rsp_nbytes = pwrite_q ? 3'd1 : 3'd5;
                    rsp_data   = apb.pslverr ? {STS_SLVERR, 32'h0}
                                             : {STS_OK, apb.prdata};
                    state_d    = ST_RESP;
                end else if (wt_q == WT_LAST) begin
                    rsp_load   = 1'b1;
                    rsp_nbytes = pwrite_q ? 3'd1 : 3'd5;
                    rsp_data   = {STS_TIMEOUT, 32'h0};
                    state_d    = ST_RESP;
                end else begin
                    wt_d = wt_q + WTW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign apb.penable = (state_q == ST_ACCESS);

    resp_shifter u_resp_shifter (
        .clk        (clk),
        .arstn      (arstn),
        .load_i     (rsp_load),
        .data_i     (rsp_data),
        .nbytes_i   (rsp_nbytes),
        .done_tx_i  (done_tx),
        .byte_tx_o  (byte_tx),
        .start_tx_o (start_tx),
        .done_o     (rsp_done)
    );

endmodule
